button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//   Board push-button input conditioner, the input-side counterpart of the LED drivers.
//   Synchronises a raw bouncing button pin and debounces it into a clean level.
//   Emits single-cycle press/release/long-press strobes and an 8-bit press counter
//   for user logic (mode select, blink-rate change). One instance per board key.
// PARAMETERS
//   DEBOUNCE_CYCLES    270_000     stable cycles required before a level change is accepted (10 ms @ 27 MHz); >= 2
//   LONG_PRESS_CYCLES  27_000_000  cycles of accepted "pressed" before long_press_o fires (1 s); > DEBOUNCE_CYCLES
//   ACTIVE_LOW         1           1: btn_i low = pressed (board keys); 0: btn_i high = pressed
// PORTS
//   clk_i          in   1  system clock (27 MHz on board)
//   reset_n_i      in   1  asynchronous active-low reset
//   btn_i          in   1  raw button pin, asynchronous to clk_i, bouncing
//   btn_level_o    out  1  debounced level, 1 = pressed (polarity normalised)
//   press_o        out  1  1-cycle strobe on accepted released->pressed
//   release_o      out  1  1-cycle strobe on accepted pressed->released
//   long_press_o   out  1  1-cycle strobe, at most once per press, after LONG_PRESS_CYCLES held
//   press_count_o  out  8  count of accepted presses, wraps 255 -> 0
// BEHAVIOUR
//   Reset (async assert, sync use on release): sync flops = released level, btn_level_o=0,
//     all strobes 0, counters 0, press_count_o=0, FSM=S_RELEASED.
//   Sync: 2-FF chain on btn_i; polarity inverted when ACTIVE_LOW=1 after the chain -> sync_q.
//   Debounce counter (width $clog2(DEBOUNCE_CYCLES)):
//     - sync_q == btn_level_o: counter cleared to 0.
//     - sync_q != btn_level_o and counter < DEBOUNCE_CYCLES-1: counter +1.
//     - sync_q != btn_level_o and counter == DEBOUNCE_CYCLES-1: btn_level_o toggles, counter cleared.
//   Latency: btn_i change set up before edge 0 -> btn_level_o changes after edge DEBOUNCE_CYCLES+1.
//   Any bounce back within the window clears the counter; a pulse shorter than
//     DEBOUNCE_CYCLES cycles (after sync) produces no output change.
//   press_o/release_o: registered, asserted in the same cycle btn_level_o first shows the new level.
//   FSM (hold timer width $clog2(LONG_PRESS_CYCLES), cleared on every state entry):
//     S_RELEASED: on accepted press -> S_PRESSED.
//     S_PRESSED : hold timer +1 per cycle; at LONG_PRESS_CYCLES-1 -> long_press_o=1 for 1 cycle,
//                 -> S_LONG; on accepted release -> S_RELEASED (no long strobe).
//     S_LONG    : timer frozen, no further strobes; on accepted release -> S_RELEASED.
//   Long-press timing: long_press_o asserts exactly LONG_PRESS_CYCLES cycles after press_o.
//   press_count_o increments in the cycle after press_o (registered), 8-bit wrap.
//   Press and release cannot coincide (one level register); strobes mutually exclusive.
//   Reset mid-press: everything returns to reset values; if the key is still held on
//     reset release, a fresh press_o is generated after the normal debounce latency.
//   btn_i stuck at one level forever: no strobes beyond the first accepted transition.
// STRUCTURE
//   Shared header board_defs.vh: CLK_HZ (27_000_000) and default ms-to-cycles constants;
//     defaults above are derived from it. FSM state encodings stay local localparams.
//   Sub-module sync_2ff (1-bit, reset value parameter) for the input synchroniser;
//     reused for every other asynchronous board input.
//   Rest flat: debounce counter, level/strobe registers, hold FSM, press counter.
// TESTING (sim with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, ACTIVE_LOW=1)
//   Reset: btn_i=1, reset_n_i low 5 cycles -> all outputs 0; stays 0 for 100 cycles after.
//   Clean press: btn_i 1->0 before edge 0 -> btn_level_o=1 and press_o=1 after edge 9 only; count=1.
//   Bounce: btn_i low 5 cycles, high 3, low 4, then high -> no strobe, btn_level_o stays 0.
//   Long press: hold 60 cycles -> long_press_o single pulse 32 cycles after press_o; release_o
//     after release+9; short hold 20 cycles -> no long_press_o.
//   Wrap: 256 clean presses -> press_count_o returns to 0, 256 press_o and release_o pulses.
//   Reset mid-press: assert reset in S_PRESSED with key held -> outputs 0; after release, press_o
//     again after 9 edges; no long_press_o before a further 32 cycles.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Board-level timing constants shared by the button conditioner and other board I/O blocks.
// Default debounce and long-press windows are derived from the board clock.
package button_debounce_pkg;

    localparam int CLK_HZ = 27_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEFAULT_DEBOUNCE_CYCLES   = ms_to_cycles(10);
    localparam int DEFAULT_LONG_PRESS_CYCLES = ms_to_cycles(1000);

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
// RESET_VAL should be the input's idle level so reset release produces no false edge.
module sync_2ff
    import button_debounce_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and derive press/release/long-press
// strobes plus a wrapping press counter from one raw board key.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       btn_i,
    output logic       btn_level_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_press_o,
    output logic [7:0] press_count_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic SYNC_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_RELEASED = 2'd0,
        S_PRESSED  = 2'd1,
        S_LONG     = 2'd2
    } state_t;

    logic              btn_sync;
    logic              sync_q;
    logic              differs;
    logic              accept;
    logic              accept_press;
    logic              accept_release;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_timer;
    logic              long_fire;
    state_t            state;
    state_t            state_next;

    sync_2ff #(
        .RESET_VAL(SYNC_IDLE)
    ) u_sync (
        .clk  (clk_i),
        .rst_n(reset_n_i),
        .d    (btn_i),
        .q    (btn_sync)
    );

    // Normalise polarity so that 1 always means pressed from here on.
    assign sync_q         = ACTIVE_LOW ? ~btn_sync : btn_sync;
    assign differs        = (sync_q != btn_level_o);
    assign accept         = differs && (db_cnt == DB_MAX);
    assign accept_press   = accept && !btn_level_o;
    assign accept_release = accept && btn_level_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            db_cnt      <= '0;
            btn_level_o <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
        end else begin
            press_o   <= accept_press;
            release_o <= accept_release;
            if (!differs || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            if (accept) begin
                btn_level_o <= ~btn_level_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= S_RELEASED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RELEASED: if (accept_press) state_next = S_PRESSED;
            S_PRESSED: begin
                if (accept_release) begin
                    state_next = S_RELEASED;
                end else if (hold_timer == HOLD_MAX) begin
                    state_next = S_LONG;
                end
            end
            S_LONG:     if (accept_release) state_next = S_RELEASED;
            default:    state_next = S_RELEASED;
        endcase
    end

    // A release on the same edge as timer expiry wins, keeping strobes exclusive.
    always_comb begin
        long_fire = 1'b0;
        if (state == S_PRESSED && hold_timer == HOLD_MAX && !accept_release) begin
            long_fire = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_timer <= '0;
        end else if (state_next != state) begin
            hold_timer <= '0;
        end else if (state == S_PRESSED) begin
            hold_timer <= hold_timer + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            long_press_o  <= 1'b0;
            press_count_o <= 8'd0;
        end else begin
            long_press_o <= long_fire;
            if (press_o) begin
                press_count_o <= press_count_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with short debounce/long-press windows.
// Expected outputs come from hand-derived edge timings relative to the button change.
module tb_button_debounce;

    localparam int DB   = 8;
    localparam int LONG = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       level;
    logic       press;
    logic       rel;
    logic       lng;
    logic [7:0] cnt;

    int checks = 0;
    int errors = 0;
    int press_seen = 0;
    int rel_seen = 0;

    typedef struct {
        logic       btn;
        logic       lvl;
        logic       p;
        logic       r;
        logic       l;
        logic [7:0] c;
    } vec_t;

    vec_t table_v[26];

    button_debounce #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LONG),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .btn_i        (btn),
        .btn_level_o  (level),
        .press_o      (press),
        .release_o    (rel),
        .long_press_o (lng),
        .press_count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic e_lvl, input logic e_p,
                         input logic e_r, input logic e_l, input logic [7:0] e_c);
        checks++;
        if (level !== e_lvl || press !== e_p || rel !== e_r || lng !== e_l || cnt !== e_c) begin
            errors++;
            $display("FAIL %s: got lvl=%b press=%b rel=%b long=%b cnt=%0d, expected lvl=%b press=%b rel=%b long=%b cnt=%0d",
                     name, level, press, rel, lng, cnt, e_lvl, e_p, e_r, e_l, e_c);
        end
    endtask

    // One press held for 'hold' cycles (btn low before edges 0..hold-1), observed for 'total' edges.
    // Press lands on edge 9, release on edge hold+9, long strobe on edge 41 if still held then.
    task automatic run_press(input string name, input int hold, input int total, input logic [7:0] base);
        for (int e = 0; e < total; e++) begin
            btn = (e < hold) ? 1'b0 : 1'b1;
            tick();
            if (press) press_seen++;
            if (rel) rel_seen++;
            check($sformatf("%s_e%0d", name, e),
                  (e >= DB + 1) && (e < hold + DB + 1),
                  (e == DB + 1),
                  (e == hold + DB + 1),
                  (e == DB + 1 + LONG) && (hold + DB + 1 > DB + 1 + LONG),
                  (e >= DB + 2) ? base + 8'd1 : base);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b1;

        // Reset and idle with the key released
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("reset_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("idle_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // Clean press and release, table-driven
        for (int i = 0; i < 26; i++) begin
            table_v[i].btn = (i < 15) ? 1'b0 : 1'b1;
            table_v[i].lvl = (i >= 9) && (i < 24);
            table_v[i].p   = (i == 9);
            table_v[i].r   = (i == 24);
            table_v[i].l   = 1'b0;
            table_v[i].c   = (i >= 10) ? 8'd1 : 8'd0;
        end
        for (int i = 0; i < 26; i++) begin
            btn = table_v[i].btn;
            tick();
            check($sformatf("clean_e%0d", i), table_v[i].lvl, table_v[i].p,
                  table_v[i].r, table_v[i].l, table_v[i].c);
        end

        // Bounce: low 5, high 3, low 4, then high; nothing accepted
        for (int i = 0; i < 32; i++) begin
            btn = ((i < 5) || (i >= 8 && i < 12)) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("bounce_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        end

        run_press("long", 60, 80, 8'd1);
        run_press("short", 20, 40, 8'd2);

        // 256 presses: counter passes through 0 after 253 and returns to its start value
        press_seen = 0;
        rel_seen = 0;
        for (int n = 0; n < 256; n++) begin
            run_press($sformatf("wrap%0d", n), 12, 24, 8'(3 + n));
            if (n == 252) check("wrap_zero", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        checks++;
        if (press_seen != 256 || rel_seen != 256) begin
            errors++;
            $display("FAIL wrap_pulses: got press=%0d release=%0d, expected 256 and 256", press_seen, rel_seen);
        end
        check("wrap_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);

        // Reset while held in the pressed state
        btn = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("pre_reset_held", 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
        rst_n = 1'b0;
        #1;
        check("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_mid_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        rst_n = 1'b1;
        run_press("after_reset", 50, 62, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
